// File: rtl/cmp_share_arbiter_pkg.sv
// cmp_share_pkg: shared FSM state type and index-width helper for cmp_share_arbiter
package cmp_share_pkg;
  typedef enum logic [1:0] {IDLE, CMP, RESP} cmp_state_e;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cmp_share_arbiter_rr_picker.sv
// cmp_rr_picker: combinational round-robin pick of the first request after the last grant
module cmp_rr_picker
  import cmp_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o
);
  logic [ID_W-1:0] c;
  // scan offsets from farthest to nearest so the nearest valid slot after ptr_i wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    c = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = ID_W'((int'(ptr_i) + k) % NREQ);
      if (req_i[c]) begin
        gnt_o = NREQ'(1) << c;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin shared equality comparator; CMP_SHARE_MAG_EN adds rsp_lt
module cmp_share_arbiter
  import cmp_share_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int ID_W = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_equal,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy
`ifdef CMP_SHARE_MAG_EN
  , output logic            rsp_lt
`endif
);
  cmp_state_e      state_q;
  logic [N-1:0]    a_q, b_q, a_sel, b_sel;
  logic [ID_W-1:0] id_q, ptr_q, w_idx, rsp_id_q;
  logic [NREQ-1:0] gnt, rsp_valid_q;
  logic            eq_q;
`ifdef CMP_SHARE_MAG_EN
  logic            lt_q;
  assign rsp_lt = lt_q;
`endif
  cmp_rr_picker #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (w_idx)
  );
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign busy      = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_equal = eq_q;
  assign rsp_id    = rsp_id_q;
  // steer the winner's operands out of the packed request buses
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end
  // accept in IDLE, compare in CMP, pulse the tagged response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      ptr_q       <= ID_W'(NREQ - 1);
      eq_q        <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= '0;
`ifdef CMP_SHARE_MAG_EN
      lt_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          a_q     <= a_sel;
          b_q     <= b_sel;
          id_q    <= w_idx;
          ptr_q   <= w_idx;
          state_q <= CMP;
        end
        CMP: begin
          eq_q        <= &(~(a_q ^ b_q));
`ifdef CMP_SHARE_MAG_EN
          lt_q        <= a_q < b_q;
`endif
          rsp_id_q    <= id_q;
          rsp_valid_q <= NREQ'(1) << id_q;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed table-driven checks of cmp_share_arbiter (honours CMP_SHARE_MAG_EN)
module tb_cmp_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic        rsp_equal, busy;
  logic [1:0]  rsp_id;
  int          errors = 0, checks = 0;
`ifdef CMP_SHARE_MAG_EN
  logic        rsp_lt;
`endif
  always #5 clk = ~clk;
  cmp_share_arbiter #(.N(4), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_equal (rsp_equal),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef CMP_SHARE_MAG_EN
    , .rsp_lt  (rsp_lt)
`endif
  );
  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a, b;
    int          id;
    logic        eq, lt;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic xact(input vec_t v);
    @(negedge clk);
    req_valid = v.valid;
    req_a = v.a;
    req_b = v.b;
    #1 chk("ready", 32'(req_ready), 32'(4'b1 << v.id));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("cmp_busy", 32'(busy), 1);
    chk("cmp_ready", 32'(req_ready), 0);
    chk("cmp_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(4'b1 << v.id));
    chk("rsp_equal", 32'(rsp_equal), 32'(v.eq));
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
`ifdef CMP_SHARE_MAG_EN
    chk("rsp_lt", 32'(rsp_lt), 32'(v.lt));
`endif
  endtask
  initial begin
    vecs[0] = '{4'b0001, 16'h000A, 16'h000A, 0, 1'b1, 1'b0};
    vecs[1] = '{4'b0100, 16'h0500, 16'h0400, 2, 1'b0, 1'b0};
    vecs[2] = '{4'b0100, 16'h0400, 16'h0500, 2, 1'b0, 1'b1};
    vecs[3] = '{4'b1111, 16'h3210, 16'h3F10, 3, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 16'h1234, 16'h1235, 0, 1'b0, 1'b1};
    vecs[5] = '{4'b0110, 16'h0F70, 16'h0070, 1, 1'b1, 1'b0};
    vecs[6] = '{4'b0011, 16'h00C9, 16'h00C8, 0, 1'b0, 1'b0};
    vecs[7] = '{4'b0001, 16'h0008, 16'h0000, 0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_ready", 32'(req_ready), 0);
    end
    chk("reset_rsp_equal", 32'(rsp_equal), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    // all four held high: grants rotate 0,1,2,3 three cycles apart
    req_a = 16'h1234;
    req_b = 16'h1234;
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rot_ready", 32'(req_ready), (k % 3 == 0) ? 32'(4'b1 << (k / 3)) : 0);
      chk("rot_rsp_valid", 32'(rsp_valid), (k % 3 == 2) ? 32'(4'b1 << (k / 3)) : 0);
      if (k % 3 == 2) chk("rot_rsp_id", 32'(rsp_id), k / 3);
      @(negedge clk);
    end
    req_valid = '0;
    // async reset while in CMP drops the transaction
    @(negedge clk);
    req_a = '0;
    req_b = 16'h0001;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    #1 chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_equal", 32'(rsp_equal), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    xact('{4'b1111, 16'h0000, 16'h0000, 0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) xact(vecs[i]);
    // req1 raises then drops valid while req3 is served
    @(negedge clk);
    req_a = 16'h7000;
    req_b = 16'h7000;
    req_valid = 4'b1000;
    #1 chk("drop_ready3", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0010;
    #1 chk("drop_cmp_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
    chk("drop_rsp_id", 32'(rsp_id), 3);
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drop_no_rsp", 32'(rsp_valid), 0);
      chk("drop_no_busy", 32'(busy), 0);
      chk("drop_no_ready", 32'(req_ready), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
